// File: rtl/axi_stream_mux_4ch_if.sv
// AXI-Stream bundle (data/dest/user/tlast/valid/ready) shared by the mux inputs and output.
interface axi_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
    logic                  tlast;
    logic                  valid;
    logic                  ready;

    modport master (output data, dest, user, tlast, valid, input ready);
    modport slave  (input data, dest, user, tlast, valid, output ready);
endinterface

// File: rtl/axi_stream_mux_4ch.sv
// 4-to-1 AXI-Stream mux with a one-beat registered output stage.
// Optional AXIS_MUX_PACKET_LOCK_EN: selection only moves between packets (after tlast).
module axi_stream_mux_4ch #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] address,
    axi_stream.slave   stream_in_1,
    axi_stream.slave   stream_in_2,
    axi_stream.slave   stream_in_3,
    axi_stream.slave   stream_in_4,
    axi_stream.master  stream_out
);

    logic [1:0]            rst_sync_q;
    logic                  rst_int_n;
    logic [1:0]            sel_q, sel_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DEST_WIDTH-1:0] dest_q, dest_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic                  last_q, last_d;

    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DEST_WIDTH-1:0] sel_dest;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  sel_last;
    logic                  accept_rdy;
    logic                  load;

    // Assert asynchronously, release two clocks after the external reset rises.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_dest  = '0;
        sel_user  = '0;
        sel_last  = 1'b0;
        unique case (sel_q)
            2'd0: begin
                sel_valid = stream_in_1.valid; sel_data = stream_in_1.data;
                sel_dest  = stream_in_1.dest;  sel_user = stream_in_1.user;
                sel_last  = stream_in_1.tlast;
            end
            2'd1: begin
                sel_valid = stream_in_2.valid; sel_data = stream_in_2.data;
                sel_dest  = stream_in_2.dest;  sel_user = stream_in_2.user;
                sel_last  = stream_in_2.tlast;
            end
            2'd2: begin
                sel_valid = stream_in_3.valid; sel_data = stream_in_3.data;
                sel_dest  = stream_in_3.dest;  sel_user = stream_in_3.user;
                sel_last  = stream_in_3.tlast;
            end
            2'd3: begin
                sel_valid = stream_in_4.valid; sel_data = stream_in_4.data;
                sel_dest  = stream_in_4.dest;  sel_user = stream_in_4.user;
                sel_last  = stream_in_4.tlast;
            end
        endcase
    end

    // No beat is accepted while the internal reset is still held.
    assign accept_rdy = rst_int_n && (stream_out.ready || !valid_q);
    assign load       = sel_valid && accept_rdy;

    assign stream_in_1.ready = accept_rdy && (sel_q == 2'd0);
    assign stream_in_2.ready = accept_rdy && (sel_q == 2'd1);
    assign stream_in_3.ready = accept_rdy && (sel_q == 2'd2);
    assign stream_in_4.ready = accept_rdy && (sel_q == 2'd3);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        dest_d  = dest_q;
        user_d  = user_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            dest_d  = sel_dest;
            user_d  = sel_user;
            last_d  = sel_last;
        end else if (valid_q && stream_out.ready) begin
            valid_d = 1'b0;
        end
    end

`ifdef AXIS_MUX_PACKET_LOCK_EN
    logic locked_q, locked_d;

    always_comb begin
        locked_d = load ? !sel_last : locked_q;
        sel_d    = locked_d ? sel_q : address;
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) locked_q <= 1'b0;
        else            locked_q <= locked_d;
    end
`else
    assign sel_d = address;
`endif

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            data_q  <= '0;
            dest_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            user_q  <= user_d;
            last_q  <= last_d;
        end
    end

    assign stream_out.valid = valid_q;
    assign stream_out.data  = data_q;
    assign stream_out.dest  = dest_q;
    assign stream_out.user  = user_q;
    assign stream_out.tlast = last_q;

endmodule

// File: tb/tb_axi_stream_mux_4ch.sv
// Self-checking bench for axi_stream_mux_4ch: directed cases plus random traffic vs a queue model.
module tb_axi_stream_mux_4ch;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  de;
        logic [7:0]  u;
        logic        l;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data  [4];
    logic [7:0]  in_dest  [4];
    logic [7:0]  in_user  [4];
    logic        in_last  [4];
    logic        in_valid [4];

    int checks = 0;
    int errors = 0;

    beat_t sb[$];
    beat_t dlv[$];
    int    m_sel  = 0;
    bit    m_lock = 1'b0;
    int    m_sync = 0;

    axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(8), .USER_WIDTH(8)) s_in1 ();
    axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(8), .USER_WIDTH(8)) s_in2 ();
    axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(8), .USER_WIDTH(8)) s_in3 ();
    axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(8), .USER_WIDTH(8)) s_in4 ();
    axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(8), .USER_WIDTH(8)) s_out ();

    assign s_in1.data = in_data[0]; assign s_in1.dest = in_dest[0]; assign s_in1.user = in_user[0];
    assign s_in1.tlast = in_last[0]; assign s_in1.valid = in_valid[0];
    assign s_in2.data = in_data[1]; assign s_in2.dest = in_dest[1]; assign s_in2.user = in_user[1];
    assign s_in2.tlast = in_last[1]; assign s_in2.valid = in_valid[1];
    assign s_in3.data = in_data[2]; assign s_in3.dest = in_dest[2]; assign s_in3.user = in_user[2];
    assign s_in3.tlast = in_last[2]; assign s_in3.valid = in_valid[2];
    assign s_in4.data = in_data[3]; assign s_in4.dest = in_dest[3]; assign s_in4.user = in_user[3];
    assign s_in4.tlast = in_last[3]; assign s_in4.valid = in_valid[3];
    assign s_out.ready = out_ready;

    wire [3:0] rdy = {s_in4.ready, s_in3.ready, s_in2.ready, s_in1.ready};

    axi_stream_mux_4ch #(.DATA_WIDTH(32), .DEST_WIDTH(8), .USER_WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .stream_in_1 (s_in1),
        .stream_in_2 (s_in2),
        .stream_in_3 (s_in3),
        .stream_in_4 (s_in4),
        .stream_out  (s_out)
    );

    always #5 clock = ~clock;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(int k, logic [31:0] d, logic [7:0] de, logic [7:0] u, logic l, logic v);
        in_data[k] = d; in_dest[k] = de; in_user[k] = u; in_last[k] = l; in_valid[k] = v;
    endtask

    task automatic rand_in(int k, logic v);
        set_in(k, $urandom, 8'($urandom), 8'($urandom), 1'($urandom), v);
    endtask

    task automatic idle_all();
        for (int k = 0; k < 4; k++) rand_in(k, 1'b0);
    endtask

    // One clock: check DUT against the model, then advance the model across the rising edge.
    task automatic cycle();
        bit    done;
        bit    exp_rdy;
        bit    load;
        bit    hs;
        bit    lock_next;
        beat_t nb;
        #1;
        done = (m_sync == 2);
        for (int k = 0; k < 4; k++) begin
            exp_rdy = done && (k == m_sel) && (out_ready || sb.size() == 0);
            chk($sformatf("ready%0d", k), 64'(rdy[k]), 64'(exp_rdy));
        end
        chk("out_valid", 64'(s_out.valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("out_data", 64'(s_out.data), 64'(sb[0].d));
            chk("out_dest", 64'(s_out.dest), 64'(sb[0].de));
            chk("out_user", 64'(s_out.user), 64'(sb[0].u));
            chk("out_last", 64'(s_out.tlast), 64'(sb[0].l));
        end
        load = done && in_valid[m_sel] && (out_ready || sb.size() == 0);
        hs   = (sb.size() != 0) && out_ready;
        nb   = '{in_data[m_sel], in_dest[m_sel], in_user[m_sel], in_last[m_sel]};
        @(posedge clock);
        if (done) begin
            if (hs) dlv.push_back(sb.pop_front());
            if (load) sb.push_back(nb);
            lock_next = load ? !nb.l : m_lock;
`ifdef AXIS_MUX_PACKET_LOCK_EN
            if (!lock_next) m_sel = int'(address);
            m_lock = lock_next;
`else
            m_sel = int'(address);
`endif
        end
        if (m_sync < 2) m_sync++;
        @(negedge clock);
    endtask

    task automatic do_reset(int n);
        reset = 1'b0;
        sb.delete();
        m_sel = 0; m_lock = 1'b0; m_sync = 0;
        repeat (n) begin
            for (int k = 0; k < 4; k++) rand_in(k, 1'($urandom));
            out_ready = 1'($urandom);
            address   = 2'($urandom);
            #1;
            chk("rst_valid", 64'(s_out.valid), 64'd0);
            chk("rst_data",  64'(s_out.data),  64'd0);
            chk("rst_dest",  64'(s_out.dest),  64'd0);
            chk("rst_user",  64'(s_out.user),  64'd0);
            chk("rst_last",  64'(s_out.tlast), 64'd0);
            chk("rst_ready", 64'(rdy),         64'd0);
            @(negedge clock);
        end
        reset = 1'b1;
        idle_all();
        address = 2'd0;
        cycle();
        cycle();
    endtask

    initial begin
        idle_all();
        #2;
        @(negedge clock);
        do_reset(5);

        // Each channel in turn; unselected inputs show random traffic.
        for (int k = 0; k < 4; k++) begin
            address = 2'(k); out_ready = 1'b1; idle_all();
            cycle();
            for (int j = 0; j < 4; j++) rand_in(j, 1'($urandom));
            if (k == 0) set_in(0, 32'hDEADBEEF, 8'd7, 8'h5A, 1'b0, 1'b1);
            else        set_in(k, 32'hC0DE0000 + 32'(k), 8'(k), 8'(16 * k), 1'b1, 1'b1);
            cycle();
            #1;
            chk("ch_valid", 64'(s_out.valid), 64'd1);
            chk("ch_data",  64'(s_out.data),  (k == 0) ? 64'hDEADBEEF : 64'hC0DE0000 + 64'(k));
            idle_all();
            cycle();
            #1;
            chk("ch_one_beat", 64'(s_out.valid), 64'd0);
        end

        // Beat on an unselected channel must be dropped.
        address = 2'd2; idle_all();
        cycle();
        set_in(0, 32'h12345678, 8'd1, 8'd2, 1'b1, 1'b1);
        cycle();
        idle_all();
        cycle();
        #1;
        chk("wrong_ch_valid", 64'(s_out.valid), 64'd0);

        // Backpressure: 0x11 held, then 0x11, 0x22 delivered in order.
        address = 2'd0; out_ready = 1'b0; idle_all();
        cycle();
        set_in(0, 32'h11, 8'd1, 8'd1, 1'b0, 1'b1);
        cycle();
        set_in(0, 32'h22, 8'd2, 8'd2, 1'b1, 1'b1);
        cycle();
        cycle();
        #1;
        chk("bp_hold_data",  64'(s_out.data),  64'h11);
        chk("bp_hold_ready", 64'(rdy[0]),      64'd0);
        out_ready = 1'b1;
        cycle();
        in_valid[0] = 1'b0;
        cycle();
        cycle();
        chk("bp_order_first",  64'(dlv[dlv.size()-2].d), 64'h11);
        chk("bp_order_second", 64'(dlv[dlv.size()-1].d), 64'h22);

        // Three-beat packet on input 0 while the address moves to 1 after beat 1.
        address = 2'd0; out_ready = 1'b1; idle_all();
        cycle();
        set_in(0, 32'hA1, 8'd0, 8'd0, 1'b0, 1'b1);
        cycle();
        address = 2'd1;
        set_in(1, 32'hB1, 8'd1, 8'd1, 1'b1, 1'b1);
        set_in(0, 32'hA2, 8'd0, 8'd0, 1'b0, 1'b1);
        cycle();
        set_in(0, 32'hA3, 8'd0, 8'd0, 1'b1, 1'b1);
        cycle();
        in_valid[0] = 1'b0;
        cycle();
        cycle();
        in_valid[1] = 1'b0;
        cycle();
`ifdef AXIS_MUX_PACKET_LOCK_EN
        chk("lock_b1", 64'(dlv[dlv.size()-4].d), 64'hA1);
        chk("lock_b2", 64'(dlv[dlv.size()-3].d), 64'hA2);
        chk("lock_b3", 64'(dlv[dlv.size()-2].d), 64'hA3);
        chk("lock_next", 64'(dlv[dlv.size()-1].d), 64'hB1);
`endif

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) rand_in(k, 1'($urandom_range(0, 2) != 0));
            out_ready = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) address = 2'($urandom);
            cycle();
        end

        // Reset while a beat is held.
        address = 2'd3; out_ready = 1'b0; idle_all();
        cycle();
        set_in(3, 32'h55AA55AA, 8'd3, 8'd3, 1'b1, 1'b1);
        cycle();
        #1;
        chk("mid_pre_valid", 64'(s_out.valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(s_out.valid), 64'd0);
        @(negedge clock);
        do_reset(3);
        out_ready = 1'b1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
